// File: rtl/mandelbrot_pixel_scheduler.sv
// Raster-order pixel scheduler for the Mandelbrot calculator: generates Q15.16 coordinates,
// launches one calculation per pixel and streams each iteration count out on a valid/ready port.
module mandelbrot_pixel_scheduler #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   a_min,
    input  logic [31:0]   b_max,
    input  logic [31:0]   a_step,
    input  logic [31:0]   b_step,
    output logic          busy,
    output logic          frame_done,
    output logic [31:0]   calc_initial_a,
    output logic [31:0]   calc_initial_b,
    output logic          calc_en,
    input  logic          calc_ready,
    input  logic [15:0]   calc_iterations,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [15:0]   pix_iter
);

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_OUTPUT
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [31:0]   r_aMin;
    logic [31:0]   r_aStep;
    logic [31:0]   r_bStep;
    logic [31:0]   r_curA;
    logic [31:0]   r_curB;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [15:0]   r_iter;
    logic          r_busy;
    logic          r_frameDone;

    logic w_accept;
    logic w_handshake;
    logic w_lastX;
    logic w_lastY;

    // A start coinciding with the frame_done cycle is not treated as a new frame request.
    assign w_accept    = (r_state == S_IDLE) && start && !r_frameDone;
    assign w_handshake = (r_state == S_OUTPUT) && pix_ready;
    assign w_lastX     = (r_x == X_LAST);
    assign w_lastY     = (r_y == Y_LAST);

    assign busy           = r_busy;
    assign frame_done     = r_frameDone;
    assign calc_initial_a = r_curA;
    assign calc_initial_b = r_curB;
    assign pix_x          = r_x;
    assign pix_y          = r_y;
    assign pix_iter       = r_iter;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        calc_en     = 1'b0;
        pix_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (calc_ready) begin
                    calc_en     = 1'b1;
                    w_nextState = S_WAIT_BUSY;
                end
            end
            // Ready is still high in the launch cycle, so completion only counts after it drops.
            S_WAIT_BUSY: begin
                if (!calc_ready) begin
                    w_nextState = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (calc_ready) begin
                    w_nextState = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                pix_valid = 1'b1;
                if (pix_ready) begin
                    w_nextState = (w_lastX && w_lastY) ? S_IDLE : S_ISSUE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Coordinates only move on a pixel handshake, keeping them stable for the whole calculation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aMin      <= '0;
            r_aStep     <= '0;
            r_bStep     <= '0;
            r_curA      <= '0;
            r_curB      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_iter      <= '0;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            if (w_accept) begin
                r_aMin  <= a_min;
                r_aStep <= a_step;
                r_bStep <= b_step;
                r_curA  <= a_min;
                r_curB  <= b_max;
                r_x     <= '0;
                r_y     <= '0;
                r_busy  <= 1'b1;
            end
            if ((r_state == S_WAIT_DONE) && calc_ready) begin
                r_iter <= calc_iterations;
            end
            if (w_handshake) begin
                if (!w_lastX) begin
                    r_x    <= r_x + XW'(1);
                    r_curA <= r_curA + r_aStep;
                end else if (!w_lastY) begin
                    r_x    <= '0;
                    r_curA <= r_aMin;
                    r_y    <= r_y + YW'(1);
                    r_curB <= r_curB - r_bStep;
                end else begin
                    r_frameDone <= 1'b1;
                    r_busy      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Directed bench for mandelbrot_pixel_scheduler on a 4x3 grid with a behavioural
// escape-time calculator attached; expected pixels come from a hand-filled table.
module tb_mandelbrot_pixel_scheduler;

    localparam int H_RES = 4;
    localparam int V_RES = 3;
    localparam int XW    = 2;
    localparam int YW    = 2;
    localparam int NPIX  = H_RES * V_RES;

    localparam logic [31:0] A_M2 = 32'hFFFE0000;
    localparam logic [31:0] A_M1 = 32'hFFFF0000;
    localparam logic [31:0] A_0  = 32'h00000000;
    localparam logic [31:0] A_P1 = 32'h00010000;
    localparam logic [31:0] B_P1 = 32'h00010000;
    localparam logic [31:0] B_0  = 32'h00000000;
    localparam logic [31:0] B_M1 = 32'hFFFF0000;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [15:0]   iter;
    } pixRec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   a_min, b_max, a_step, b_step;
    logic          busy, frame_done, calc_en, calc_ready, pix_valid, pix_ready;
    logic [31:0]   calc_initial_a, calc_initial_b;
    logic [15:0]   calc_iterations, pix_iter;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;

    pixRec_t expTable[NPIX];
    pixRec_t got[NPIX];
    int      gotCount;
    int      checks = 0;
    int      errors = 0;
    logic    stallActive;
    logic    holdLow;

    int          enCount = 0, overlapCount = 0, stallEnSeen = 0, coordErrs = 0, doneCount = 0;
    logic        monActive = 1'b0, monSawLow = 1'b0;
    logic [31:0] monA, monB;

    logic        calcRdyReg;
    int          calcCnt;
    logic [15:0] calcIterReg;

    always #5 clk = ~clk;

    mandelbrot_pixel_scheduler #(
        .H_RES(H_RES), .V_RES(V_RES), .XW(XW), .YW(YW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_min(a_min), .b_max(b_max), .a_step(a_step), .b_step(b_step),
        .busy(busy), .frame_done(frame_done),
        .calc_initial_a(calc_initial_a), .calc_initial_b(calc_initial_b),
        .calc_en(calc_en), .calc_ready(calc_ready), .calc_iterations(calc_iterations),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_iter(pix_iter)
    );

    function automatic int mandelIter(input logic signed [31:0] ca, input logic signed [31:0] cb);
        longint zr = 0;
        longint zi = 0;
        longint cr = ca;
        longint ci = cb;
        longint tr;
        for (int n = 1; n <= 100; n++) begin
            tr = ((zr * zr - zi * zi) >>> 16) + cr;
            zi = ((2 * zr * zi) >>> 16) + ci;
            zr = tr;
            if ((zr * zr + zi * zi) > (64'sd4 <<< 32)) return n;
        end
        return 100;
    endfunction

    // Calculator model: ready drops after a launch and rises again with the escape count.
    assign calc_ready      = calcRdyReg && !holdLow;
    assign calc_iterations = calcIterReg;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            calcRdyReg  <= 1'b1;
            calcCnt     <= 0;
            calcIterReg <= '0;
        end else if (calcRdyReg) begin
            if (calc_en) begin
                calcRdyReg  <= 1'b0;
                calcIterReg <= 16'(mandelIter(calc_initial_a, calc_initial_b));
                calcCnt     <= 2 + (mandelIter(calc_initial_a, calc_initial_b) % 4);
            end
        end else if (calcCnt > 1) begin
            calcCnt <= calcCnt - 1;
        end else begin
            calcRdyReg <= 1'b1;
        end
    end

    // Passive monitor sampled mid low-phase, after the main process has driven inputs.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            monActive = 1'b0;
            monSawLow = 1'b0;
        end else begin
            if (calc_en) begin
                enCount++;
                monA      = calc_initial_a;
                monB      = calc_initial_b;
                monActive = 1'b1;
                monSawLow = 1'b0;
                if (pix_valid) overlapCount++;
                if (stallActive) stallEnSeen++;
            end else if (monActive) begin
                if ((calc_initial_a != monA) || (calc_initial_b != monB)) coordErrs++;
                if (!calc_ready) monSawLow = 1'b1;
                else if (monSawLow) monActive = 1'b0;
            end
            if (frame_done) doneCount++;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] aMin, input logic [31:0] bMax,
                                 input logic [31:0] aStep, input logic [31:0] bStep);
        a_min  = aMin;
        b_max  = bMax;
        a_step = aStep;
        b_step = bStep;
        start  = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic servicePixel(input int stallCycles, input int enBase);
        int      waitCyc;
        pixRec_t snap;
        waitCyc = 0;
        while (!pix_valid && waitCyc < 2000) begin
            @(negedge clk);
            #1;
            waitCyc++;
        end
        if (!pix_valid) begin
            checkOutput("pixel_timeout", 128'(pix_valid), 128'(1));
            return;
        end
        snap = '{pix_x, pix_y, calc_initial_a, calc_initial_b, pix_iter};
        if (stallCycles > 0) begin
            stallActive = 1'b1;
            for (int i = 0; i < stallCycles; i++) begin
                @(negedge clk);
                #1;
                checkOutput("stall_hold", {pix_valid, pix_x, pix_y, pix_iter},
                            {1'b1, snap.x, snap.y, snap.iter});
            end
            stallActive = 1'b0;
            checkOutput("stall_no_en", 128'(stallEnSeen), 128'(0));
        end
        if (gotCount < NPIX) got[gotCount] = snap;
        gotCount++;
        pix_ready = 1'b1;
        @(negedge clk);
        #1;
        pix_ready = 1'b0;
        checkOutput("en_per_pixel", 128'(enCount - enBase), 128'(gotCount));
    endtask

    task automatic compareFrame(input string tag);
        checkOutput({tag, "_pixel_count"}, 128'(gotCount), 128'(NPIX));
        for (int i = 0; i < NPIX; i++) begin
            checkOutput($sformatf("%s_pixel%0d", tag, i), 128'(got[i]), 128'(expTable[i]));
        end
    endtask

    initial begin
        int enBase;
        int doneBase;
        int waitCyc;

        expTable[0]  = '{2'd0, 2'd0, A_M2, B_P1, 16'd1};
        expTable[1]  = '{2'd1, 2'd0, A_M1, B_P1, 16'd3};
        expTable[2]  = '{2'd2, 2'd0, A_0,  B_P1, 16'd100};
        expTable[3]  = '{2'd3, 2'd0, A_P1, B_P1, 16'd2};
        expTable[4]  = '{2'd0, 2'd1, A_M2, B_0,  16'd100};
        expTable[5]  = '{2'd1, 2'd1, A_M1, B_0,  16'd100};
        expTable[6]  = '{2'd2, 2'd1, A_0,  B_0,  16'd100};
        expTable[7]  = '{2'd3, 2'd1, A_P1, B_0,  16'd3};
        expTable[8]  = '{2'd0, 2'd2, A_M2, B_M1, 16'd1};
        expTable[9]  = '{2'd1, 2'd2, A_M1, B_M1, 16'd3};
        expTable[10] = '{2'd2, 2'd2, A_0,  B_M1, 16'd100};
        expTable[11] = '{2'd3, 2'd2, A_P1, B_M1, 16'd2};

        rst         = 1'b0;
        start       = 1'b0;
        pix_ready   = 1'b0;
        holdLow     = 1'b0;
        stallActive = 1'b0;
        a_min = '0; b_max = '0; a_step = '0; b_step = '0;
        gotCount = 0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_outputs",
                    {busy, frame_done, calc_en, pix_valid, calc_initial_a, calc_initial_b, pix_x, pix_y, pix_iter}, '0);
        rst = 1'b1;
        @(negedge clk);
        #1;

        // Frame 1: calculator busy at the first ISSUE, backpressure on pixel (1,0).
        holdLow  = 1'b1;
        enBase   = enCount;
        doneBase = doneCount;
        applyStimulus(A_M2, B_P1, 32'h00010000, 32'h00010000);
        checkOutput("busy_after_start", 128'(busy), 128'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checkOutput("issue_stall_en", {calc_en, pix_valid}, 2'b00);
        end
        holdLow = 1'b0;
        #1;
        checkOutput("issue_release_en", {calc_en, pix_valid}, 2'b10);
        for (int p = 0; p < NPIX; p++) begin
            if (p == 5) begin
                a_min = 32'h12340000;
                b_max = 32'h7FFF0000;
                start = 1'b1;
                @(negedge clk);
                #1;
                start = 1'b0;
                checkOutput("start_while_busy", 128'(busy), 128'(1));
            end
            servicePixel((p == 1) ? 5 : 0, enBase);
        end
        checkOutput("frame_done_pulse", {frame_done, busy, pix_valid}, 3'b100);
        @(negedge clk);
        #1;
        checkOutput("frame_done_one_cycle", {frame_done, busy, calc_en}, 3'b000);
        checkOutput("en_total", 128'(enCount - enBase), 128'(NPIX));
        checkOutput("coord_stable", 128'(coordErrs), 128'(0));
        checkOutput("no_valid_with_en", 128'(overlapCount), 128'(0));
        checkOutput("done_count_f1", 128'(doneCount - doneBase), 128'(1));
        compareFrame("f1");

        // Frame 2: asynchronous reset while pixel (2,1) is being calculated.
        gotCount = 0;
        enBase   = enCount;
        doneBase = doneCount;
        applyStimulus(A_M2, B_P1, 32'h00010000, 32'h00010000);
        for (int p = 0; p < 6; p++) servicePixel(0, enBase);
        waitCyc = 0;
        while ((enCount - enBase) < 7 && waitCyc < 50) begin
            @(negedge clk);
            #1;
            waitCyc++;
        end
        checkOutput("abort_en_reached", 128'(enCount - enBase), 128'(7));
        @(negedge clk);
        #1;
        checkOutput("abort_point_xy", {busy, pix_x, pix_y}, {1'b1, 2'd2, 2'd1});
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    {busy, frame_done, calc_en, pix_valid, calc_initial_a, calc_initial_b, pix_x, pix_y, pix_iter}, '0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("abort_no_frame_done", {128'(doneCount - doneBase)}, 128'(0));

        // Frame 3: fresh start after reset must restart from pixel (0,0).
        gotCount = 0;
        enBase   = enCount;
        doneBase = doneCount;
        applyStimulus(A_M2, B_P1, 32'h00010000, 32'h00010000);
        for (int p = 0; p < NPIX; p++) servicePixel(0, enBase);
        checkOutput("frame_done_pulse_f3", {frame_done, busy}, 2'b10);
        @(negedge clk);
        #1;
        checkOutput("idle_after_f3", {frame_done, busy, calc_en, pix_valid}, 4'b0000);
        checkOutput("done_count_f3", 128'(doneCount - doneBase), 128'(1));
        checkOutput("coord_stable_all", 128'(coordErrs), 128'(0));
        compareFrame("f3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
